// File: rtl/vdma_pkg.sv
// vdma_pkg: shared types, constants and timing helpers for the VDMA video blocks.
package vdma_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vid_state_t;

  localparam logic [23:0] BLACK_PIXEL = 24'h0;

  // Total length of a line or frame from its four regions.
  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width for a 0..total-1 count, never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/vdma_timing_cnt.sv
// vdma_timing_cnt: horizontal/vertical raster counters with region decode.
// The counters hold at zero while clear is high, and step only when advance is high.
module vdma_timing_cnt
  import vdma_pkg::*;
#(
  parameter int H_ACTIVE = 192,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 8,
  parameter int H_BP     = 4,
  parameter int V_ACTIVE = 10,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  parameter int HW       = cnt_width(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW       = cnt_width(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active_h,
  output logic          active_v,
  output logic          hsync_region,
  output logic          vsync_region,
  output logic          last_pixel
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] H_ACT_END   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);

  // Raster position: h_cnt steps every advancing clock, v_cnt steps on h_cnt wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clear) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) begin
          v_cnt <= '0;
        end else begin
          v_cnt <= v_cnt + 1'b1;
        end
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      h_cnt <= h_cnt;
      v_cnt <= v_cnt;
    end
  end

  assign active_h     = (h_cnt < H_ACT_END);
  assign active_v     = (v_cnt < V_ACT_END);
  assign hsync_region = (h_cnt >= H_SYNC_LO) && (h_cnt <= H_SYNC_HI);
  assign vsync_region = (v_cnt >= V_SYNC_LO) && (v_cnt <= V_SYNC_HI);
  assign last_pixel   = (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/vdma_axis_vid_out.sv
// vdma_axis_vid_out: pulls 32-bit AXI-Stream pixel words and emits registered
// raster video (hsync/vsync/de/rgb). Starved active pixels go out black and
// are counted; the raster never slips.
// Optional: define VDMA_VID_OUT_SOF_RESYNC_EN to add s_axis_tuser and stall
// the raster at pixel (0,0) until a start-of-frame word arrives.
module vdma_axis_vid_out
  import vdma_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 192,
  parameter int IMAGE_HEIGHT = 10,
  parameter int H_FP         = 4,
  parameter int H_SYNC       = 8,
  parameter int H_BP         = 4,
  parameter int V_FP         = 1,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 1
)(
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
`ifdef VDMA_VID_OUT_SOF_RESYNC_EN
  input  logic        s_axis_tuser,
`endif
  output logic        s_axis_tready,
  input  logic        vid_enable,
  output logic        vid_hsync,
  output logic        vid_vsync,
  output logic        vid_de,
  output logic [23:0] vid_data,
  output logic        vid_sof,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int HW = cnt_width(calc_total(IMAGE_WIDTH, H_FP, H_SYNC, H_BP));
  localparam int VW = cnt_width(calc_total(IMAGE_HEIGHT, V_FP, V_SYNC, V_BP));

  vid_state_t      state;
  vid_state_t      next_state;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            active_h;
  logic            active_v;
  logic            hsync_region;
  logic            vsync_region;
  logic            last_pixel;
  logic            run;
  logic            first_pixel;
  logic            pix_slot;
  logic            stall;
  logic            advance;
  logic            pix_de;
  logic            unused_tdata;

  // Alpha/pad byte of the stream word carries nothing for this output.
  assign unused_tdata = ^s_axis_tdata[31:24];

  vdma_timing_cnt #(
    .H_ACTIVE (IMAGE_WIDTH),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (IMAGE_HEIGHT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk          (s_axis_aclk),
    .rst          (s_axis_areset),
    .clear        (~run),
    .advance      (advance),
    .h_cnt        (h_cnt),
    .v_cnt        (v_cnt),
    .active_h     (active_h),
    .active_v     (active_v),
    .hsync_region (hsync_region),
    .vsync_region (vsync_region),
    .last_pixel   (last_pixel)
  );

  // State register.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: start on enable, stop only at the end of a complete frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (vid_enable) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last_pixel && !vid_enable) begin
          next_state = IDLE;
        end else begin
          next_state = RUN;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Per-clock control decode from state and raster position.
  always_comb begin
    run         = (state == RUN);
    first_pixel = (h_cnt == '0) && (v_cnt == '0);
    pix_slot    = run && active_h && active_v;
`ifdef VDMA_VID_OUT_SOF_RESYNC_EN
    stall       = run && first_pixel && !(s_axis_tvalid && s_axis_tuser);
`else
    stall       = 1'b0;
`endif
    advance       = run && !stall;
    pix_de        = pix_slot && !stall;
    s_axis_tready = pix_slot;
  end

  // Registered video outputs and the saturating starvation counter.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      vid_hsync     <= 1'b0;
      vid_vsync     <= 1'b0;
      vid_de        <= 1'b0;
      vid_data      <= BLACK_PIXEL;
      vid_sof       <= 1'b0;
      underflow     <= 1'b0;
      underflow_cnt <= 16'h0000;
    end else begin
      vid_hsync <= run && hsync_region;
      vid_vsync <= run && vsync_region;
      vid_de    <= pix_de;
      vid_data  <= (pix_de && s_axis_tvalid) ? s_axis_tdata[23:0] : BLACK_PIXEL;
      vid_sof   <= pix_de && first_pixel;
      underflow <= pix_de && !s_axis_tvalid;
      if (pix_de && !s_axis_tvalid && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end else begin
        underflow_cnt <= underflow_cnt;
      end
    end
  end

endmodule

// File: tb/tb_vdma_axis_vid_out.sv
// tb_vdma_axis_vid_out: directed bench for vdma_axis_vid_out with a
// linear-frame-position reference model checked every cycle, plus
// hand-computed expectations per scenario.
// Define VDMA_VID_OUT_SOF_RESYNC_EN to build and exercise the resync variant.
module tb_vdma_axis_vid_out;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int HFP = 1;
  localparam int HS  = 2;
  localparam int HBP = 1;
  localparam int VFP = 1;
  localparam int VS  = 1;
  localparam int VBP = 1;
  localparam int HT  = W + HFP + HS + HBP;
  localparam int VT  = H + VFP + VS + VBP;
  localparam int FT  = HT * VT;
`ifdef VDMA_VID_OUT_SOF_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tuser;
  logic        s_axis_tready;
  logic        vid_enable;
  logic        vid_hsync;
  logic        vid_vsync;
  logic        vid_de;
  logic [23:0] vid_data;
  logic        vid_sof;
  logic        underflow;
  logic [15:0] underflow_cnt;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [23:0] word;

  vdma_axis_vid_out #(
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .H_FP         (HFP),
    .H_SYNC       (HS),
    .H_BP         (HBP),
    .V_FP         (VFP),
    .V_SYNC       (VS),
    .V_BP         (VBP)
  ) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
`ifdef VDMA_VID_OUT_SOF_RESYNC_EN
    .s_axis_tuser  (s_axis_tuser),
`endif
    .s_axis_tready (s_axis_tready),
    .vid_enable    (vid_enable),
    .vid_hsync     (vid_hsync),
    .vid_vsync     (vid_vsync),
    .vid_de        (vid_de),
    .vid_data      (vid_data),
    .vid_sof       (vid_sof),
    .underflow     (underflow),
    .underflow_cnt (underflow_cnt)
  );

  always #5 clk = ~clk;

  // Raster geometry of a linear frame position p in 0..FT-1.
  function automatic bit m_act(input int p);
    return ((p % HT) < W) && ((p / HT) < H);
  endfunction

  function automatic bit m_hs(input int p);
    int x;
    x = p % HT;
    return (x >= W + HFP) && (x < W + HFP + HS);
  endfunction

  function automatic bit m_vs(input int p);
    int y;
    y = p / HT;
    return (y >= H + VFP) && (y < H + VFP + VS);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: one frame position advanced per non-stalled running clock.
  bit          m_run;
  int          m_pos;
  int          m_ucnt;
  logic        m_stall;
  logic        exp_hs, exp_vs, exp_de, exp_sof, exp_uf;
  logic [23:0] exp_data;
  logic        exp_tready;

  assign m_stall    = RESYNC && m_run && (m_pos == 0) && !(s_axis_tvalid && s_axis_tuser);
  assign exp_tready = m_run && m_act(m_pos);

  // Model update on every clock (reset is asynchronous, as in the block).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run <= 1'b0; m_pos <= 0; m_ucnt <= 0;
      exp_hs <= 1'b0; exp_vs <= 1'b0; exp_de <= 1'b0; exp_sof <= 1'b0; exp_uf <= 1'b0;
      exp_data <= 24'h0;
    end else if (!m_run) begin
      exp_hs <= 1'b0; exp_vs <= 1'b0; exp_de <= 1'b0; exp_sof <= 1'b0; exp_uf <= 1'b0;
      exp_data <= 24'h0;
      m_pos <= 0;
      m_run <= vid_enable;
    end else begin
      exp_hs   <= m_hs(m_pos);
      exp_vs   <= m_vs(m_pos);
      exp_de   <= m_act(m_pos) && !m_stall;
      exp_sof  <= (m_pos == 0) && !m_stall;
      exp_uf   <= m_act(m_pos) && !m_stall && !s_axis_tvalid;
      exp_data <= (m_act(m_pos) && !m_stall && s_axis_tvalid) ? s_axis_tdata[23:0] : 24'h0;
      if (m_act(m_pos) && !m_stall && !s_axis_tvalid && (m_ucnt < 65535)) m_ucnt <= m_ucnt + 1;
      if (!m_stall) m_pos <= (m_pos + 1) % FT;
      if ((m_pos == FT - 1) && !vid_enable) m_run <= 1'b0;
    end
  end

  function automatic logic [45:0] dut_vec();
    return {s_axis_tready, vid_hsync, vid_vsync, vid_de, vid_sof, underflow, vid_data, underflow_cnt};
  endfunction

  function automatic logic [45:0] exp_vec();
    return {exp_tready, exp_hs, exp_vs, exp_de, exp_sof, exp_uf, exp_data, m_ucnt[15:0]};
  endfunction

  // Monitor state, written only by the compare process.
  logic [23:0] seen[$];
  int ncyc = 0, sof_n = 0, hs_n = 0, vs_n = 0, de_n = 0, tr_n = 0, uf_n = 0;
  int sof_cyc = 0, hs_off = -1, vs_off = -1;
  logic [23:0] sof_data = 24'h0;
  bit hs_arm = 1'b0, vs_arm = 1'b0;

  // Compare against the model on every falling edge and record output activity.
  always @(negedge clk) begin
    check("cycle", {18'h0, dut_vec()}, {18'h0, exp_vec()});
    ncyc <= ncyc + 1;
    if (vid_de) seen.push_back(vid_data);
    if (vid_de) de_n <= de_n + 1;
    if (s_axis_tready) tr_n <= tr_n + 1;
    if (underflow) uf_n <= uf_n + 1;
    if (vid_sof) begin
      sof_n <= sof_n + 1; sof_data <= vid_data; sof_cyc <= ncyc;
      hs_arm <= 1'b1; vs_arm <= 1'b1;
    end
    if (vid_hsync) begin
      hs_n <= hs_n + 1;
      if (hs_arm) begin hs_off <= ncyc - sof_cyc; hs_arm <= 1'b0; end
    end
    if (vid_vsync) begin
      vs_n <= vs_n + 1;
      if (vs_arm) begin vs_off <= ncyc - sof_cyc; vs_arm <= 1'b0; end
    end
  end

  // One stream/enable setting, sampled by the next rising edge.
  task automatic drive(input bit v, input bit u, input bit en);
    @(posedge clk); #2;
    vid_enable    = en;
    s_axis_tvalid = v;
    s_axis_tuser  = u;
    s_axis_tdata  = {8'hA5, word};
    if (v && s_axis_tready) word = word + 24'd1;
  endtask

  // n clocks of a frame, call p sampled at frame position p.
  task automatic frame(input int drop_p, input int dis_p, input int n);
    for (int p = 0; p < n; p++) begin
      drive(p != drop_p, p == 0, (dis_p < 0) || (p < dis_p));
    end
  endtask

  // Pixels seen since base: ramp from first, with a black pixel at zero_at.
  task automatic check_seq(input string nm, input int base, input logic [23:0] first,
                           input int n, input int zero_at);
    logic [31:0] act;
    logic [23:0] req;
    check({nm, "_count"}, seen.size() - base, n);
    for (int i = 0; i < n; i++) begin
      act = (base + i < seen.size()) ? {8'h0, seen[base + i]} : 32'hFFFF_FFFF;
      if (i == zero_at) req = 24'h0;
      else if ((zero_at >= 0) && (i > zero_at)) req = first + 24'(i - 1);
      else req = first + 24'(i);
      check($sformatf("%s_px%0d", nm, i), act, {8'h0, req});
    end
  endtask

  int b_q, b_sof, b_hs, b_vs, b_uf, b_de, b_tr;

  task automatic snap();
    #1;
    b_q = seen.size(); b_sof = sof_n; b_hs = hs_n; b_vs = vs_n;
    b_uf = uf_n; b_de = de_n; b_tr = tr_n;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vid_enable = 1'b1; s_axis_tvalid = 1'b1; s_axis_tuser = 1'b0;
    s_axis_tdata = 32'hA512_3456; word = 24'd1;
    // 1: reset held with valid data waiting.
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", {18'h0, dut_vec()}, 64'h0);
    rst = 1'b0; vid_enable = 1'b0; s_axis_tvalid = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // 2: always-valid ramp 1..8 over one frame.
    snap();
    drive(1'b1, 1'b0, 1'b1);
    frame(-1, -1, FT);
    @(negedge clk); #1;
    check_seq("ramp", b_q, 24'd1, 8, -1);
    check("ramp_sof_n", sof_n - b_sof, 1);
    check("ramp_sof_data", sof_data, 24'd1);
    check("ramp_hsync_n", hs_n - b_hs, 10);
    check("ramp_vsync_n", vs_n - b_vs, 8);
    check("ramp_hsync_off", hs_off, 5);
    check("ramp_vsync_off", vs_off, 24);

    // 3: third pixel of line 0 starved.
    snap();
    frame(2, -1, FT);
    @(negedge clk); #1;
    check_seq("starve", b_q, 24'd9, 8, 2);
    check("starve_uf_n", uf_n - b_uf, 1);
    check("starve_uf_cnt", underflow_cnt, 16'd1);

    // 4: enable dropped during line 1 -- frame completes, then idle.
    snap();
    frame(-1, 8, FT);
    @(negedge clk); #1;
    check_seq("stop", b_q, 24'd16, 8, -1);
    snap();
    repeat (16) drive(1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    check("idle_de_n", de_n - b_de, 0);
    check("idle_tready_n", tr_n - b_tr, 0);

    // 5: reset mid-line 1, then restart on the next queued word.
    drive(1'b1, 1'b0, 1'b1);
    snap();
    frame(-1, -1, 10);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("reset_async", {18'h0, dut_vec()}, 64'h0);
    check_seq("pre_reset", b_q, 24'd24, 5, -1);
    drive(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    snap();
    frame(-1, -1, FT);
    @(negedge clk); #1;
    check_seq("restart", b_q, 24'd30, 8, -1);
    check("restart_sof_n", sof_n - b_sof, 1);
    check("restart_sof_data", sof_data, 24'd30);

`ifdef VDMA_VID_OUT_SOF_RESYNC_EN
    // 6: two non-SOF words discarded before the SOF word 0xAA.
    snap();
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    word = 24'hAA;
    frame(-1, -1, FT);
    @(negedge clk); #1;
    check_seq("resync", b_q, 24'hAA, 8, -1);
    check("resync_sof_n", sof_n - b_sof, 1);
    check("resync_sof_data", sof_data, 24'hAA);
`endif

    repeat (50) drive(1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
